exchange_scheduler: RTL and testbench

Sequences the replica-exchange step of the parallel-tempering annealer. On each `start` it streams the total distance of every replica out of the energy store. It applies a Metropolis test to each adjacent replica pair using an externally supplied log-random threshold. It then publishes one `exchange_command_t` per replica, and the replica datapaths use those commands to swap (PREV/FOLW) or keep (SELF) their tours. Pairing alternates between even and odd phases on successive runs.

---
 rtl/exchange_scheduler.sv | 133 +++++++++++++
 tb/tb_exchange_scheduler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/exchange_scheduler.sv
// Replica-exchange sequencer for the parallel-tempering annealer.
// Streams replica energies, runs Metropolis tests, publishes swap commands.
package exchange_pkg;
  typedef enum logic [1:0] {
    NOP  = 2'd0,
    SELF = 2'd1,
    PREV = 2'd2,
    FOLW = 2'd3
  } exchange_command_t;
  typedef logic [22:0] total_data_t;
  localparam logic [3:0] dbeta = 4'd5;
endpackage

module exchange_scheduler
  import exchange_pkg::*;
#(
  parameter int replica_num = 32,
  parameter int addr_w = $clog2(replica_num)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  output logic                     busy,
  output logic [addr_w-1:0]        e_addr,
  input  total_data_t              e_rdata,
  input  logic [26:0]              rnd_data,
  output logic                     rnd_ack,
  output logic [replica_num*2-1:0] cmd,
  output logic                     cmd_valid,
  output logic                     done,
  output logic                     phase
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [addr_w-1:0]        r_addr;
  logic [addr_w-1:0]        r_ridx;
  logic [addr_w-1:0]        w_lo;
  logic                     r_rvalid;
  logic                     r_par;
  logic                     r_phase;
  logic                     r_cmd_valid;
  total_data_t              r_eprev;
  logic [replica_num*2-1:0] r_cmd;
  logic [23:0]              w_diff;
  logic [26:0]              w_prod;
  logic                     w_pos;
  logic                     w_cmp;
  logic                     w_acc;
  logic                     w_start;
  logic                     w_last;

  assign w_start = (r_state == S_IDLE) && start;
  assign w_last  = (r_addr == addr_w'(replica_num - 1));

  // Next-state sequencing of one exchange run
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DRAIN;
      S_DRAIN: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Metropolis test on the pair whose upper member arrives this cycle
  always_comb begin
    w_lo    = r_ridx - addr_w'(1);
    w_cmp   = r_rvalid && (r_ridx[0] != r_phase) && (r_ridx != '0);
    w_diff  = {1'b0, r_eprev} - {1'b0, e_rdata};
    w_pos   = !w_diff[23] && (w_diff != '0);
    w_prod  = {4'b0, w_diff[22:0]} * {23'b0, dbeta};
    w_acc   = !w_pos || (w_prod <= rnd_data);
    rnd_ack = w_cmp && w_pos;
  end

  // Address counter, read tracking, parity and command registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr      <= '0;
      r_ridx      <= '0;
      r_rvalid    <= 1'b0;
      r_eprev     <= '0;
      r_par       <= 1'b0;
      r_phase     <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_cmd       <= '0;
    end else begin
      r_rvalid <= (r_state == S_RUN);
      r_ridx   <= r_addr;
      if (r_rvalid) r_eprev <= e_rdata;
      if (w_start) begin
        r_addr      <= '0;
        r_phase     <= r_par;
        r_cmd       <= {replica_num{SELF}};
        r_cmd_valid <= 1'b0;
      end else if (r_state == S_RUN && !w_last) begin
        r_addr <= r_addr + addr_w'(1);
      end else if (r_state == S_DONE) begin
        r_addr <= '0;
      end
      if (r_state == S_DRAIN) r_cmd_valid <= 1'b1;
      if (r_state == S_DONE)  r_par <= ~r_par;
      if (w_cmp && w_acc) begin
        r_cmd[{w_lo, 1'b0} +: 2]   <= FOLW;
        r_cmd[{r_ridx, 1'b0} +: 2] <= PREV;
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign e_addr    = r_addr;
  assign cmd       = r_cmd;
  assign cmd_valid = r_cmd_valid;
  assign phase     = r_phase;

endmodule

// File: tb/tb_exchange_scheduler.sv
// Scoreboard bench for exchange_scheduler with four replicas.
// Directed energy sets, hand-computed command vectors.
module tb_exchange_scheduler;
  import exchange_pkg::*;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic [1:0]  e_addr;
  logic [22:0] e_rdata;
  logic [26:0] rnd_data = '0;
  logic        rnd_ack;
  logic [7:0]  cmd;
  logic        cmd_valid;
  logic        done;
  logic        phase;

  always #5 clk = ~clk;

  exchange_scheduler #(.replica_num(N)) u_dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .busy(busy),
    .e_addr(e_addr),
    .e_rdata(e_rdata),
    .rnd_data(rnd_data),
    .rnd_ack(rnd_ack),
    .cmd(cmd),
    .cmd_valid(cmd_valid),
    .done(done),
    .phase(phase)
  );

  logic [22:0] mem [N];
  always @(posedge clk) e_rdata <= mem[e_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int acks = 0;
  int ack_cyc = -1;
  always @(negedge clk)
    if (reset_n && rnd_ack) begin
      acks++;
      ack_cyc = cyc;
    end

  typedef struct {
    logic [7:0] cmd;
    logic       ph;
    int         t0;
    int         nack;
    int         ackrel;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] pk(input exchange_command_t c0,
                                    input exchange_command_t c1,
                                    input exchange_command_t c2,
                                    input exchange_command_t c3);
    return {c3, c2, c1, c0};
  endfunction

  // Monitor: every done pulse must match the oldest expected run
  always @(negedge clk)
    if (reset_n && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        m = q.pop_front();
        chk("cmd", cmd, m.cmd);
        chk("cmd_valid", cmd_valid, 1);
        chk("phase", phase, m.ph);
        chk("latency", cyc - m.t0, N + 2);
        chk("ack_count", acks, m.nack);
        if (m.nack > 0) chk("ack_cycle", ack_cyc - m.t0, m.ackrel);
      end
    end

  task automatic run(input logic [22:0] e0, input logic [22:0] e1,
                     input logic [22:0] e2, input logic [22:0] e3,
                     input logic [26:0] rnd, input logic [7:0] ecmd,
                     input logic eph, input int nack, input int ackrel,
                     input bit busy_start);
    exp_t it;
    int   k;
    mem[0] = e0;
    mem[1] = e1;
    mem[2] = e2;
    mem[3] = e3;
    rnd_data = rnd;
    @(negedge clk);
    acks = 0;
    ack_cyc = -1;
    it.cmd = ecmd;
    it.ph = eph;
    it.t0 = cyc;
    it.nack = nack;
    it.ackrel = ackrel;
    q.push_back(it);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (busy_start) begin
      @(negedge clk);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    k = 0;
    while (q.size() != 0 && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("run_completed", q.size(), 0);
    @(negedge clk);
    chk("busy_dropped", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_cmd", cmd, 0);
      chk("idle_phase", phase, 0);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_cmd_valid", cmd_valid, 0);
      chk("idle_rnd_ack", rnd_ack, 0);
    end
    // even: (0,1) diff 0, (2,3) diff -50
    run(30, 30, 50, 100, 0, pk(FOLW, PREV, FOLW, PREV), 0, 0, 0, 0);
    // odd: (1,2) diff 5 prod 25 <= 30
    run(0, 10, 5, 7, 30, pk(SELF, FOLW, PREV, SELF), 1, 1, 4, 0);
    // even: (0,1) prod 250 <= 250
    run(60, 10, 0, 0, 250, pk(FOLW, PREV, FOLW, PREV), 0, 1, 3, 0);
    // odd: (1,2) diff 10 prod 50 <= 250
    run(60, 10, 0, 0, 250, pk(SELF, FOLW, PREV, SELF), 1, 1, 4, 0);
    // even: (0,1) prod 250 > 249 rejected
    run(60, 10, 0, 0, 249, pk(SELF, SELF, FOLW, PREV), 0, 1, 3, 0);
    // odd with start pulsed mid-run
    run(5, 5, 5, 5, 0, pk(SELF, FOLW, PREV, SELF), 1, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_second_run", busy, 0);
    end
    // even: all differences negative
    run(0, 1, 2, 3, 0, pk(FOLW, PREV, FOLW, PREV), 0, 0, 0, 0);
    // odd run aborted by reset in cycle 3
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort_busy", busy, 1);
    chk("abort_phase", phase, 1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_phase", phase, 0);
    chk("rst_done", done, 0);
    reset_n = 1'b1;
    @(negedge clk);
    run(30, 30, 50, 100, 0, pk(FOLW, PREV, FOLW, PREV), 0, 0, 0, 0);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
